// File: rtl/mul_z_pkg.sv
// Shared types and constants for the multiplier Z-register sequencer.
package mul_z_pkg;

  localparam int MUL_Z_WIDTH = 32;
  localparam int MUL_Z_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_SEND_LO = 2'd2,
    ST_SEND_HI = 2'd3
  } mul_z_state_t;

endpackage

// File: rtl/mul_settle_counter.sv
// Loadable down-counter timing the multiplier settle window; o_last flags count==1.
// Single-cycle load, decrements once per enabled cycle and saturates at zero.
module mul_settle_counter
  import mul_z_pkg::*;
(
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   i_load,
  input  logic [MUL_Z_CNT_W-1:0] i_load_val,
  input  logic                   i_dec,
  output logic                   o_last
);

  logic [MUL_Z_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == MUL_Z_CNT_W'(1));

endmodule

// File: rtl/mul_z_sequencer.sv
// Latches operands, waits MUL_LAT cycles, captures the product, then sends LO then HI over valid/ready;
// all outputs registered, a bus stall holds the offered word. Optional ovf flag under MUL_Z_OVF_EN.
module mul_z_sequencer
  import mul_z_pkg::*;
#(
  parameter int WIDTH   = MUL_Z_WIDTH,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   mplr,
  input  logic [WIDTH-1:0]   mcnd,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   zlo,
  output logic [WIDTH-1:0]   zhi,
  output logic [WIDTH-1:0]   bus_out,
  output logic               bus_valid,
  output logic               bus_sel,
  input  logic               bus_ready,
  output logic               busy,
  output logic               done
`ifdef MUL_Z_OVF_EN
 ,output logic               ovf
`endif
);

  localparam logic [MUL_Z_CNT_W-1:0] LP_LAT = MUL_Z_CNT_W'(MUL_LAT);

  mul_z_state_t r_state;
  mul_z_state_t w_next;
  logic         w_last;
  logic         w_load;
  logic         w_capture;

  logic [WIDTH-1:0] r_mul_a, r_mul_b, r_zlo, r_zhi, r_bus_out;
  logic             r_bus_valid, r_bus_sel, r_busy, r_done;

  assign w_load    = (r_state == ST_IDLE) && start;
  assign w_capture = (r_state == ST_SETTLE) && w_last;

  mul_settle_counter u_cnt (
    .clk        (clk),
    .clr        (clr),
    .i_load     (w_load),
    .i_load_val (LP_LAT),
    .i_dec      (r_state == ST_SETTLE),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (!clr) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start)     w_next = ST_SETTLE;
      ST_SETTLE:  if (w_last)    w_next = ST_SEND_LO;
      ST_SEND_LO: if (bus_ready) w_next = ST_SEND_HI;
      ST_SEND_HI: if (bus_ready) w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  // Output registers track the transition being taken, so every output is a flop.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_zlo       <= '0;
      r_zhi       <= '0;
      r_bus_out   <= '0;
      r_bus_valid <= 1'b0;
      r_bus_sel   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_mul_a <= mplr;
        r_mul_b <= mcnd;
        r_busy  <= 1'b1;
      end
      if (w_capture) begin
        r_zlo       <= prod[WIDTH-1:0];
        r_zhi       <= prod[2*WIDTH-1:WIDTH];
        r_bus_out   <= prod[WIDTH-1:0];
        r_bus_valid <= 1'b1;
        r_bus_sel   <= 1'b0;
      end
      if ((r_state == ST_SEND_LO) && bus_ready) begin
        r_bus_out <= r_zhi;
        r_bus_sel <= 1'b1;
      end
      if ((r_state == ST_SEND_HI) && bus_ready) begin
        r_bus_valid <= 1'b0;
        r_bus_sel   <= 1'b0;
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
      end
    end
  end

`ifdef MUL_Z_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk) begin
    if (!clr)           r_ovf <= 1'b0;
    else if (w_capture) r_ovf <= (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
  end
  assign ovf = r_ovf;
`endif

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign zlo       = r_zlo;
  assign zhi       = r_zhi;
  assign bus_out   = r_bus_out;
  assign bus_valid = r_bus_valid;
  assign bus_sel   = r_bus_sel;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mul_z_sequencer.sv
// Directed bench for mul_z_sequencer with a behavioural signed multiplier on mul_a/mul_b.
module tb_mul_z_sequencer;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic [W-1:0]     mplr, mcnd;
  logic [W-1:0]     mul_a, mul_b;
  logic [2*W-1:0]   prod;
  logic [W-1:0]     zlo, zhi, bus_out;
  logic             bus_valid, bus_sel, bus_ready, busy, done;
`ifdef MUL_Z_OVF_EN
  logic             ovf;
`endif

  logic signed [2*W-1:0] prod_s;
  assign prod_s = $signed(mul_a) * $signed(mul_b);
  assign prod   = prod_s;

  always #5 clk = ~clk;

  mul_z_sequencer #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .mplr      (mplr),
    .mcnd      (mcnd),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .prod      (prod),
    .zlo       (zlo),
    .zhi       (zhi),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .bus_sel   (bus_sel),
    .bus_ready (bus_ready),
    .busy      (busy),
    .done      (done)
`ifdef MUL_Z_OVF_EN
   ,.ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] zhi;
    logic [W-1:0] zlo;
    logic         ovf;
  } vec_t;

  vec_t vecs[7];
  int total = 0;
  int bad   = 0;
  logic [W:0] words[$];

  // Record every accepted bus word as {sel, data}.
  always @(negedge clk) begin
    if (clr && bus_valid && bus_ready) words.push_back({bus_sel, bus_out});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic run_vec(input vec_t v, input bit chain);
    int n;
    words.delete();
    mplr = v.a; mcnd = v.b; start = 1'b1; bus_ready = 1'b1;
    step();
    start = 1'b0;
    check("busy_t0", busy, 1);
    check("mul_a",   mul_a, v.a);
    check("mul_b",   mul_b, v.b);
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
      if (n == LAT) begin
        check("lo_valid", bus_valid, 1);
        check("lo_sel",   bus_sel, 0);
        check("lo_data",  bus_out, v.zlo);
      end
      if (n == LAT + 1) begin
        check("hi_sel",  bus_sel, 1);
        check("hi_data", bus_out, v.zhi);
      end
    end
    check("done_lat",   n, LAT + 2);
    check("zhi",        zhi, v.zhi);
    check("zlo",        zlo, v.zlo);
    check("busy_done",  busy, 0);
    check("valid_done", bus_valid, 0);
    check("word_count", words.size(), 2);
    if (words.size() == 2) begin
      check("word0", words[0], {1'b0, v.zlo});
      check("word1", words[1], {1'b1, v.zhi});
    end
`ifdef MUL_Z_OVF_EN
    check("ovf", ovf, v.ovf);
`endif
    if (!chain) begin
      step();
      check("done_pulse", done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[1] = '{32'h0000FF00, 32'h000FFF0F, 32'h0000000F, 32'hEF0FF100, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 32'h000FFF0F, 32'hFFFFFFFF, 32'hFFF000F1, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b1};
    vecs[4] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b1};
    vecs[5] = '{32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
    vecs[6] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b1};

    clr = 1'b0; start = 1'b0; mplr = '0; mcnd = '0; bus_ready = 1'b0;
    step();
    step();
    check("rst_busy",  busy, 0);
    check("rst_valid", bus_valid, 0);
    check("rst_zlo",   zlo, 0);
    check("rst_done",  done, 0);
    clr = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

    // Back-to-back: second start lands in the done cycle of the first.
    run_vec(vecs[1], 1'b1);
    run_vec(vecs[2], 1'b0);

    // Three-cycle stall in SEND_LO with a stray start that must be ignored.
    words.delete();
    mplr = 32'h0000FF00; mcnd = 32'h000FFF0F; start = 1'b1; bus_ready = 1'b0;
    step();
    start = 1'b0;
    repeat (LAT) step();
    n = LAT;
    check("stall_valid0", bus_valid, 1);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        start = 1'b1; mplr = 32'h12345678; mcnd = 32'h00000009;
      end
      step();
      n++;
      start = 1'b0;
      check("stall_valid", bus_valid, 1);
      check("stall_data",  bus_out, 32'hEF0FF100);
      check("stall_sel",   bus_sel, 0);
    end
    bus_ready = 1'b1;
    while (!done && n < 40) begin
      step();
      n++;
    end
    check("stall_done_lat", n, LAT + 5);
    check("stall_mul_a",    mul_a, 32'h0000FF00);
    check("stall_zhi",      zhi, 32'h0000000F);
    check("stall_words",    words.size(), 2);
    if (words.size() == 2) begin
      check("stall_word0", words[0], {1'b0, 32'hEF0FF100});
      check("stall_word1", words[1], {1'b1, 32'h0000000F});
    end
    step();
    check("stall_idle", busy, 0);

    // Reset in the middle of SETTLE clears everything.
    mplr = 32'h0000FF00; mcnd = 32'h000FFF0F; start = 1'b1;
    step();
    start = 1'b0;
    step();
    clr = 1'b0;
    step();
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_zlo",   zlo, 0);
    check("mid_rst_zhi",   zhi, 0);
    check("mid_rst_valid", bus_valid, 0);
    check("mid_rst_mul_a", mul_a, 0);
    clr = 1'b1;
    repeat (LAT + 2) step();
    check("post_rst_idle", bus_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
